dac_spi_config: RTL and testbench

//   Power-up reset and SPI register programmer for the two 16-bit DAC devices (DAC0, DAC1) fed by the
//   DAC sweep/data path. After reset: pulses both DAC reset pins, writes an init table to DAC0 then DAC1,

---
 rtl/dac_spi_config.sv | 227 ++++++++++++++++++++++
 tb/tb_dac_spi_config.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_config.sv
// dac_spi_config
//   Power-up sequencer and SPI register programmer for two 16-bit DACs.
//   After reset release it holds both DAC reset pins high, waits for the
//   DACs to settle, and writes the init table to DAC0 and then to DAC1.
//   It then raises o_init_done and serves single-register read/write
//   requests, one at a time.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   o_sclk            SPI clock, idles low
//   o_sdio            SPI data towards the DACs, changes only on the sclk fall
//   o_sdio_oe         1 = sdio driven; 0 = released during the read data phase
//   i_sdo             SPI read data from the DACs (shared line)
//   o_csb0, o_csb1    DAC chip selects, active low, never both low
//   o_rst0_out/1_out  DAC reset pins, active high
//   o_init_done       set once both DACs are initialised, cleared only by rst_n
//   i_req_*           request: valid, rw (1 = read), dac, addr[4:0], wdata[7:0]
//   o_req_ready       high only when idle after initialisation
//   o_rsp_valid       one-cycle pulse at the end of each request frame
//   o_rsp_rdata       read data (0 after a write); held until the next response
//
// state  | meaning
// -------+----------------------------------------------------------
// DRST   | DAC reset pins held high for RST_CYCLES
// DWAIT  | DAC reset released, settling before the first frame
// INIT   | load the next init-table entry and its target DAC
// FRAME  | 16-bit SPI frame, csb low for 33*CLK_DIV cycles
// GAP    | csb high for CS_GAP cycles between frames
// IDLE   | initialised, waiting for a request
module dac_spi_config #(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 64,
  parameter int WAIT_CYCLES = 256,
  parameter int CS_GAP      = 4,
  parameter int INIT_LEN    = 4,
  parameter logic [INIT_LEN*13-1:0] INIT_TABLE = {13'h1F55, 13'h0280, 13'h0100, 13'h0000}
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       o_sclk,
  output logic       o_sdio,
  output logic       o_sdio_oe,
  input  logic       i_sdo,
  output logic       o_csb0,
  output logic       o_csb1,
  output logic       o_rst0_out,
  output logic       o_rst1_out,
  output logic       o_init_done,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rw,
  input  logic       i_req_dac,
  input  logic [4:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata
);

  // The INIT cycle is part of the settle time, so DWAIT itself runs one
  // cycle short and the first csb fall lands exactly WAIT_CYCLES after the
  // DAC resets drop.
  localparam int RST_LD  = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 0;
  localparam int WAIT_LD = (WAIT_CYCLES > 2) ? WAIT_CYCLES - 2 : 0;
  localparam int GAP_LD  = (CS_GAP > 1) ? CS_GAP - 1 : 0;
  localparam int MAX_LD  = (RST_LD > WAIT_LD) ? ((RST_LD > GAP_LD) ? RST_LD : GAP_LD)
                                              : ((WAIT_LD > GAP_LD) ? WAIT_LD : GAP_LD);
  localparam int CW      = (MAX_LD > 1) ? $clog2(MAX_LD + 1) : 1;
  localparam int DIV_LD  = (CLK_DIV > 1) ? CLK_DIV - 1 : 0;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW      = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int K_LAST  = INIT_LEN - 1;
  // Half-periods 0..31 carry the 16 bits (odd = sclk high); 32 is the
  // trailing sclk-low half before csb rises.
  localparam logic [5:0] HALF_LAST = 6'd32;

  typedef enum logic [2:0] {
    S_DRST, S_DWAIT, S_INIT, S_FRAME, S_GAP, S_IDLE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_div;
  logic [5:0]      r_half;
  logic [15:0]     r_word;
  logic            r_sel;
  logic            r_rd;
  logic            r_req;
  logic [7:0]      r_rx;
  logic [KW-1:0]   r_k;
  logic            r_init_dac;
  logic            r_init_done;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_rdata;
  logic [12:0]     w_entry;
  logic            w_cnt_zero;
  logic            w_div_zero;
  logic            w_init_last;
  logic            w_in_frame;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_div_zero  = (r_div == '0);
  assign w_init_last = (r_k == KW'(K_LAST)) && r_init_dac;
  assign w_in_frame  = (r_state == S_FRAME);

  always_comb begin
    w_entry = INIT_TABLE[12:0];
    for (int i = 0; i < INIT_LEN; i++) begin
      if (r_k == KW'(i)) w_entry = INIT_TABLE[13*i +: 13];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_DRST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_DRST:  if (w_cnt_zero) w_next = S_DWAIT;
      S_DWAIT: if (w_cnt_zero) w_next = S_INIT;
      S_INIT:  w_next = S_FRAME;
      S_FRAME: if (w_div_zero && (r_half == HALF_LAST)) w_next = S_GAP;
      S_GAP:   if (w_cnt_zero) w_next = (r_init_done || w_init_last) ? S_IDLE : S_INIT;
      S_IDLE: begin
        if (i_req_valid) begin
          w_accept = 1'b1;
          w_next   = S_FRAME;
        end
      end
      default: w_next = S_DRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= CW'(RST_LD);
      r_div       <= '0;
      r_half      <= '0;
      r_word      <= '0;
      r_sel       <= 1'b0;
      r_rd        <= 1'b0;
      r_req       <= 1'b0;
      r_rx        <= '0;
      r_k         <= '0;
      r_init_dac  <= 1'b0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_DRST: r_cnt <= w_cnt_zero ? CW'(WAIT_LD) : r_cnt - CW'(1);
        S_DWAIT: if (!w_cnt_zero) r_cnt <= r_cnt - CW'(1);
        S_INIT: begin
          r_word <= {3'b000, w_entry};
          r_sel  <= r_init_dac;
          r_rd   <= 1'b0;
          r_req  <= 1'b0;
          r_div  <= DW'(DIV_LD);
          r_half <= '0;
        end
        S_FRAME: begin
          if (w_div_zero) begin
            r_div <= DW'(DIV_LD);
            if (r_half == HALF_LAST) begin
              r_cnt <= CW'(GAP_LD);
              if (r_req) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_rd ? r_rx : 8'h00;
              end
            end else begin
              r_half <= r_half + 6'd1;
              // next bit presented as sclk falls; bit 0 is held through the tail
              if (r_half[0] && (r_half < 6'd31)) r_word <= {r_word[14:0], 1'b0};
              // sample sdo as sclk rises on edges 9..16
              if (!r_half[0] && (r_half >= 6'd16)) r_rx <= {r_rx[6:0], i_sdo};
            end
          end else begin
            r_div <= r_div - DW'(1);
          end
        end
        S_GAP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!r_init_done) begin
            if (w_init_last) begin
              r_init_done <= 1'b1;
            end else if (r_k == KW'(K_LAST)) begin
              r_k        <= '0;
              r_init_dac <= 1'b1;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_word <= {i_req_rw, 2'b00, i_req_addr, (i_req_rw ? 8'h00 : i_req_wdata)};
            r_sel  <= i_req_dac;
            r_rd   <= i_req_rw;
            r_req  <= 1'b1;
            r_div  <= DW'(DIV_LD);
            r_half <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sclk      = w_in_frame && r_half[0];
  assign o_sdio      = w_in_frame && r_word[15];
  assign o_sdio_oe   = !(w_in_frame && r_rd && (r_half >= 6'd16));
  assign o_csb0      = !(w_in_frame && !r_sel);
  assign o_csb1      = !(w_in_frame && r_sel);
  assign o_rst0_out  = (r_state == S_DRST);
  assign o_rst1_out  = (r_state == S_DRST);
  assign o_init_done = r_init_done;
  assign o_req_ready = (r_state == S_IDLE) && r_init_done;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dac_spi_config.sv
module tb_dac_spi_config;

  localparam int CLK_DIV     = 2;
  localparam int RST_CYCLES  = 8;
  localparam int WAIT_CYCLES = 16;
  localparam int CS_GAP      = 4;
  localparam int INIT_LEN    = 2;
  localparam logic [INIT_LEN*13-1:0] INIT_TABLE = {13'h1F55, 13'h0280};

  logic       clk, rst_n;
  logic       sclk, sdio, sdio_oe, sdo, csb0, csb1, rst0, rst1, init_done;
  logic       req_valid, req_ready, req_rw, req_dac;
  logic [4:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       rsp_valid;

  dac_spi_config #(
    .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .WAIT_CYCLES(WAIT_CYCLES),
    .CS_GAP(CS_GAP), .INIT_LEN(INIT_LEN), .INIT_TABLE(INIT_TABLE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .o_sclk(sclk), .o_sdio(sdio), .o_sdio_oe(sdio_oe), .i_sdo(sdo),
    .o_csb0(csb0), .o_csb1(csb1), .o_rst0_out(rst0), .o_rst1_out(rst1),
    .o_init_done(init_done),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_rw(req_rw),
    .i_req_dac(req_dac), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        dac;
    logic [15:0] word;
    logic        rd;
  } frame_t;

  frame_t     sb_q[$];
  logic [7:0] rsp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // bus monitor state
  int          mon_rises, mon_low, mon_oe0, mon_gap, frames_since_rst, rsp_cnt;
  bit          mon_in_frame, mon_first, prev_sclk, prev_rsp, prev_init, early_ready;
  logic        mon_dac;
  logic [15:0] mon_sh;
  logic [7:0]  sdo_val;

  initial begin
    mon_rises = 0; mon_low = 0; mon_oe0 = 0; mon_gap = 0; frames_since_rst = 0; rsp_cnt = 0;
    mon_in_frame = 0; mon_first = 1; prev_sclk = 0; prev_rsp = 0; prev_init = 0;
    early_ready = 0; mon_dac = 0; mon_sh = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in_frame = 0;
        mon_first = 1;
        mon_gap = 0;
        frames_since_rst = 0;
        prev_rsp = 0;
        prev_init = 0;
        prev_sclk = 0;
      end else begin
        if (!mon_in_frame) begin
          if (!csb0 || !csb1) begin
            mon_in_frame = 1;
            mon_rises = 0;
            mon_sh = '0;
            mon_low = 1;
            mon_oe0 = sdio_oe ? 0 : 1;
            mon_dac = csb0;
            chk("csb_overlap", 32'(!csb0 && !csb1), 0);
            if (!mon_first) chk("csb_gap_min", 32'(mon_gap >= CS_GAP), 1);
            mon_first = 0;
          end else begin
            mon_gap++;
          end
        end else if (csb0 && csb1) begin
          mon_in_frame = 0;
          mon_gap = 1;
          frames_since_rst++;
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            frame_t e;
            e = sb_q.pop_front();
            chk("frame_word", mon_sh, e.word);
            chk("frame_dac", mon_dac, e.dac);
            chk("sclk_rises", mon_rises, 16);
            chk("csb_low_cycles", mon_low, 33*CLK_DIV);
            chk("oe_low_cycles", mon_oe0, e.rd ? 17*CLK_DIV : 0);
          end
        end else begin
          mon_low++;
          if (!sdio_oe) mon_oe0++;
          if (sclk && !prev_sclk) begin
            mon_sh = {mon_sh[14:0], sdio};
            mon_rises++;
          end
        end
        prev_sclk = sclk;

        if (rsp_valid) begin
          chk("rsp_one_cycle", prev_rsp, 0);
          rsp_cnt++;
          if (rsp_q.size() == 0) chk("rsp_underflow", 1, 0);
          else chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
        end
        prev_rsp = rsp_valid;

        if (init_done && !prev_init) begin
          chk("init_done_frames", frames_since_rst, 2*INIT_LEN);
          chk("init_done_csb_high", 32'(mon_in_frame), 0);
        end
        prev_init = init_done;
        if (req_ready && !init_done) early_ready = 1;
      end
    end
  end

  // DAC read-data model: next bit shifted out as sclk falls after edges 8..15
  initial begin
    sdo = 1'b0;
    forever begin
      @(negedge sclk);
      if (mon_rises >= 8 && mon_rises <= 15) sdo = sdo_val[15 - mon_rises];
    end
  end

  bit         has_prev;
  int         last_acc;
  logic [7:0] last_rsp_exp;

  task automatic chk_reset_vals();
    chk("reset_outputs",
        {sclk, sdio, sdio_oe, csb0, csb1, rst0, rst1, init_done, req_ready, rsp_valid, rsp_rdata},
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic push_init();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < INIT_LEN; k++) begin
        frame_t f;
        f.dac  = d[0];
        f.word = {3'b000, INIT_TABLE[13*k +: 13]};
        f.rd   = 1'b0;
        sb_q.push_back(f);
      end
    end
  endtask

  task automatic power_up();
    int c;
    @(posedge clk);
    #1 rst_n = 1'b1;
    c = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rst0) c++;
      else break;
    end
    chk("drst_width", c, RST_CYCLES);
    chk("rst1_released", rst1, 0);
    c = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      c++;
      if (!csb0) break;
    end
    chk("wait_to_csb0", c, WAIT_CYCLES);
  endtask

  task automatic send_req(input logic rw, input logic dac, input logic [4:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd, input bit keep);
    frame_t f;
    int n;
    req_rw = rw; req_dac = dac; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 5000);
    chk("req_ready_seen", req_ready, 1);
    chk("accept_after_init", init_done, 1);
    if (has_prev) chk("rsp_before_next_accept", rsp_cnt, last_acc + 1);
    sdo_val = rd;
    f.dac  = dac;
    f.word = {rw, 2'b00, addr, (rw ? 8'h00 : wd)};
    f.rd   = rw;
    sb_q.push_back(f);
    last_rsp_exp = rw ? rd : 8'h00;
    rsp_q.push_back(last_rsp_exp);
    @(posedge clk);
    #1;
    last_acc = rsp_cnt;
    has_prev = 1;
    if (!keep) req_valid = 1'b0;
    @(negedge clk);
    chk("ready_drop", req_ready, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && rsp_q.size() == 0 && !mon_in_frame) break;
    end
    chk("scoreboard_drain", sb_q.size() + rsp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_dac = 1'b0; req_addr = '0; req_wdata = '0;
    sdo_val = '0; has_prev = 0; last_acc = 0; last_rsp_exp = '0;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals();
    push_init();

    // request held from before init completes
    req_rw = 1'b0; req_dac = 1'b1; req_addr = 5'h0B; req_wdata = 8'hA5; req_valid = 1'b1;
    power_up();
    send_req(1'b0, 1'b1, 5'h0B, 8'hA5, 8'h00, 1'b0);

    // back-to-back: read, then a write held valid behind it
    send_req(1'b1, 1'b0, 5'h1F, 8'h77, 8'h3C, 1'b1);
    send_req(1'b0, 1'b0, 5'h02, 8'hFF, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic rw, d;
      logic [4:0] a;
      logic [7:0] w, r;
      rw = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      w  = 8'($urandom_range(0, 255));
      r  = 8'($urandom_range(0, 255));
      send_req(rw, d, a, w, r, 1'b0);
    end
    drain();

    // reset in the middle of a frame
    send_req(1'b0, 1'b0, 5'h05, 8'h12, 8'h00, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (mon_in_frame && mon_rises == 7) break;
    end
    chk("reached_edge7", mon_rises, 7);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    sb_q.delete();
    rsp_q.delete();
    has_prev = 0;
    repeat (2) @(negedge clk);
    push_init();
    power_up();
    send_req(1'b1, 1'b1, 5'h03, 8'h00, 8'hC9, 1'b0);
    drain();

    repeat (4) @(negedge clk);
    chk("rdata_hold", rsp_rdata, last_rsp_exp);
    chk("no_ready_before_init", 32'(early_ready), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
